// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two-requester round-robin arbiter driving one AXI-lite master port
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata_out,
    output logic              awvalid,
    output logic [ADDR_W-1:0] awaddr,
    input  logic              awready,
    output logic              wvalid,
    output logic [DATA_W-1:0] wdata,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    output logic              rready
);
    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t            state;
    logic              gid;
    logic              last_grant;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              aw_ok, w_ok, b_seen, ar_ok, r_seen;

    logic pick, sel_we, aw_acc, w_acc, ar_acc;

    // On a tie the requester that was not served last wins.
    assign pick   = (req0 && req1) ? ~last_grant : req1;
    assign sel_we = pick ? we1 : we0;
    assign aw_acc = aw_ok || (awvalid && awready);
    assign w_acc  = w_ok  || (wvalid && wready);
    assign ar_acc = ar_ok || (arvalid && arready);

    assign awaddr = cmd_addr;
    assign araddr = cmd_addr;
    assign wdata  = cmd_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gid        <= 1'b0;
            last_grant <= 1'b1;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            aw_ok      <= 1'b0;
            w_ok       <= 1'b0;
            b_seen     <= 1'b0;
            ar_ok      <= 1'b0;
            r_seen     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gid        <= pick;
                        last_grant <= pick;
                        cmd_addr   <= pick ? addr1 : addr0;
                        cmd_wdata  <= pick ? wdata1 : wdata0;
                        if (sel_we) begin
                            state   <= WR;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            bready  <= 1'b1;
                        end else begin
                            state   <= RD;
                            arvalid <= 1'b1;
                            rready  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_ok   <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_ok   <= 1'b1;
                    end
                    // A write response may arrive before either handshake; remember it.
                    if (bvalid) b_seen <= 1'b1;
                    if (aw_acc && w_acc && (b_seen || bvalid)) begin
                        state  <= DONE;
                        bready <= 1'b0;
                        done0  <= ~gid;
                        done1  <= gid;
                    end
                end
                RD: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        ar_ok   <= 1'b1;
                    end
                    if (rvalid) begin
                        rdata_out <= rdata;
                        r_seen    <= 1'b1;
                    end
                    if (ar_acc && (r_seen || rvalid)) begin
                        state  <= DONE;
                        rready <= 1'b0;
                        done0  <= ~gid;
                        done1  <= gid;
                    end
                end
                DONE: begin
                    done0   <= 1'b0;
                    done1   <= 1'b0;
                    aw_ok   <= 1'b0;
                    w_ok    <= 1'b0;
                    b_seen  <= 1'b0;
                    ar_ok   <= 1'b0;
                    r_seen  <= 1'b0;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    arvalid <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
